// File: rtl/cla_sub_pipe.sv
// -----------------------------------------------------------------------------
// cla_sub_pipe
// Pipelined WIDTH-bit subtractor computing d = a - b - bin.
// One 4-bit carry-lookahead group is resolved per stage, so the pipe is
// STAGES = WIDTH/4 cycles deep. The subtraction is done as a + ~b + ~bin.
// Each group carry is registered and feeds the next group one stage later.
// A valid/ready handshake runs on both sides, and results leave in acceptance order.
//
// Optional feature (macro CLA_SUB_SAT_EN):
//   defined   -> signed saturation of d on two's-complement overflow
//                (0x7FF..F for a positive minuend, 0x800..0 for a negative one);
//                ovf and bout still report the raw condition
//   undefined -> d is the raw result modulo 2^WIDTH
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous reset, active-low
//   in_valid   in   1      a, b and bin are valid
//   in_ready   out  1      block accepts input this cycle
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in
//   out_valid  out  1      d, bout and ovf are valid
//   out_ready  in   1      downstream accepts the result
//   d          out  WIDTH  difference
//   bout       out  1      unsigned borrow-out (a < b + bin)
//   ovf        out  1      two's-complement overflow of a - b - bin
// -----------------------------------------------------------------------------
module cla_sub_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / 4;
    localparam int MSB    = WIDTH - 1;

    // The whole pipe moves in lock-step. It freezes only when a finished
    // result is waiting and downstream refuses it.
    logic adv;
    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    // 4-bit lookahead: every carry is a flat sum of products of p/g/c0.
    // Returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] p,
                                        input logic [3:0] g,
                                        input logic       c0);
        logic c1, c2, c3, c4;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, p ^ {c3, c2, c1, c0}};
    endfunction

`ifdef CLA_SUB_SAT_EN
    // Clamp to the signed extreme on the side the minuend's sign points to.
    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH-1:0] raw,
                                             input logic             ov,
                                             input logic             amsb);
        logic signed [WIDTH-1:0] lim;
        lim = amsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return ov ? $unsigned(lim) : raw;
    endfunction
`endif

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO = 4 * k;

        // Operand bits still to be consumed (a and ~b), the incoming carry,
        // the incoming valid, and the difference bits resolved so far
        // including this group.
        logic [WIDTH-1:LO] sa;
        logic [WIDTH-1:LO] snb;
        logic              cin;
        logic              vin;
        logic [3:0]        gs;
        logic              gc;
        logic [LO+3:0]     full;

        if (k == 0) begin : src
            assign sa   = a;
            assign snb  = ~b;
            assign cin  = ~bin;
            assign vin  = in_valid;
            assign full = gs;
        end else begin : src
            assign sa   = stg[k-1].mid.a_hi_p;
            assign snb  = stg[k-1].mid.nb_hi_p;
            assign cin  = stg[k-1].mid.cy_p;
            assign vin  = stg[k-1].mid.vld_p;
            assign full = {gs, stg[k-1].mid.dif_p};
        end

        assign {gc, gs} = cla4(sa[LO+3:LO] ^ snb[LO+3:LO],
                               sa[LO+3:LO] & snb[LO+3:LO],
                               cin);

        if (k < STAGES - 1) begin : mid
            // ---- stage k -> stage k+1 boundary ----
            logic                vld_p;
            logic [LO+3:0]       dif_p;
            logic                cy_p;
            logic [WIDTH-1:LO+4] a_hi_p;
            logic [WIDTH-1:LO+4] nb_hi_p;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p <= 1'b0;
                end else if (adv) begin
                    vld_p <= vin;
                end
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    dif_p   <= full;
                    cy_p    <= gc;
                    a_hi_p  <= sa[WIDTH-1:LO+4];
                    nb_hi_p <= snb[WIDTH-1:LO+4];
                end
            end
        end else begin : fin
            // The top group still holds a[MSB] and ~b[MSB], so the overflow
            // test needs no separately carried sign bits.
            logic             ovf_raw;
            logic [WIDTH-1:0] d_nxt;

            assign ovf_raw = (sa[MSB] != ~snb[MSB]) && (full[MSB] != sa[MSB]);

`ifdef CLA_SUB_SAT_EN
            assign d_nxt = sat(full, ovf_raw, sa[MSB]);
`else
            assign d_nxt = full;
`endif

            // ---- last stage -> output boundary ----
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    d         <= '0;
                    bout      <= 1'b0;
                    ovf       <= 1'b0;
                end else if (adv) begin
                    out_valid <= vin;
                    d         <= d_nxt;
                    bout      <= ~gc;
                    ovf       <= ovf_raw;
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_sub_pipe.sv
module tb_cla_sub_pipe;

    localparam int W = 16;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         bin       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;

    int n_vec  = 0;
    int n_miss = 0;

    // Expected results in acceptance order, packed as {bout, ovf, d}.
    logic [17:0] q[$];

    cla_sub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic on the numeric values.
    function automatic logic [17:0] model(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic         bi);
        int          ud, sd;
        logic        bo, ov;
        logic [15:0] r;
        ud = int'(x) - int'(y) - int'(bi);
        sd = int'($signed(x)) - int'($signed(y)) - int'(bi);
        bo = (ud < 0);
        ov = (sd > 32767) || (sd < -32768);
        r  = ud[15:0];
`ifdef CLA_SUB_SAT_EN
        if (ov) r = (sd > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {bo, ov, r};
    endfunction

    // One clock cycle: drive inputs at the falling edge, observe just after,
    // then let the rising edge happen. Accepted inputs go into the queue.
    task automatic cyc(input  logic         iv,
                       input  logic [W-1:0] ia,
                       input  logic [W-1:0] ib,
                       input  logic         ibin,
                       input  logic         ordy,
                       output logic         acc,
                       output logic         cons,
                       output logic         ov,
                       output logic [17:0]  obs,
                       output logic         ir);
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        bin       = ibin;
        out_ready = ordy;
        #1;
        ir   = in_ready;
        ov   = out_valid;
        acc  = iv && in_ready;
        cons = out_valid && ordy;
        obs  = {bout, ovf, d};
        if (acc) q.push_back(model(ia, ib, ibin));
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (d !== 16'h0000)     begin n_miss++; $display("FAIL rst_d: got %h want 0000", d); end
        n_vec++; if (bout !== 1'b0)      begin n_miss++; $display("FAIL rst_bout: got %b want 0", bout); end
        n_vec++; if (ovf !== 1'b0)       begin n_miss++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        n_vec++; if (in_ready !== 1'b1)  begin n_miss++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic acc, cons, ov, ir;
        logic [17:0] obs, want;
        cyc(1'b1, 16'h1234, 16'h0034, 1'b0, 1'b1, acc, cons, ov, obs, ir);
        n_vec++; if (acc !== 1'b1) begin n_miss++; $display("FAIL basic_accept: got %b want 1", acc); end
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b0, '0, '0, 1'b0, 1'b1, acc, cons, ov, obs, ir);
            n_vec++;
            if (ov !== (i == 4)) begin n_miss++; $display("FAIL basic_latency: cycle %0d out_valid=%b want %b", i, ov, (i == 4)); end
            if (cons && q.size() > 0) begin
                want = q.pop_front();
                n_vec++;
                if (obs !== want) begin n_miss++; $display("FAIL basic_data: got b/o/d=%b/%b/%h want %b/%b/%h", obs[17], obs[16], obs[15:0], want[17], want[16], want[15:0]); end
            end
        end
        n_vec++; if (q.size() != 0) begin n_miss++; $display("FAIL basic_drain: %0d results missing, want 0", q.size()); q.delete(); end
    endtask

    task automatic test_wrap();
        logic acc, cons, ov, ir;
        logic [17:0] obs, want;
        logic [W-1:0] ta [2] = '{16'h0000, 16'h0005};
        logic [W-1:0] tb [2] = '{16'h0001, 16'h0005};
        logic         tc [2] = '{1'b0, 1'b1};
        for (int c = 0; c < 10; c++) begin
            if (c < 2) cyc(1'b1, ta[c], tb[c], tc[c], 1'b1, acc, cons, ov, obs, ir);
            else       cyc(1'b0, '0, '0, 1'b0, 1'b1, acc, cons, ov, obs, ir);
            if (cons) begin
                n_vec++;
                if (q.size() == 0) begin n_miss++; $display("FAIL wrap_spurious: d=%h, want no result", obs[15:0]); end
                else begin
                    want = q.pop_front();
                    if (obs !== want) begin n_miss++; $display("FAIL wrap_data: got b/o/d=%b/%b/%h want %b/%b/%h", obs[17], obs[16], obs[15:0], want[17], want[16], want[15:0]); end
                end
            end
        end
        n_vec++; if (q.size() != 0) begin n_miss++; $display("FAIL wrap_drain: %0d results missing, want 0", q.size()); q.delete(); end
    endtask

    task automatic test_ovf();
        logic acc, cons, ov, ir;
        logic [17:0] obs, want;
        logic [W-1:0] ta [3] = '{16'h8000, 16'h7FFF, 16'h8000};
        logic [W-1:0] tb [3] = '{16'h0001, 16'hFFFF, 16'h0000};
        logic         tc [3] = '{1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 10; c++) begin
            if (c < 3) cyc(1'b1, ta[c], tb[c], tc[c], 1'b1, acc, cons, ov, obs, ir);
            else       cyc(1'b0, '0, '0, 1'b0, 1'b1, acc, cons, ov, obs, ir);
            if (cons) begin
                n_vec++;
                if (q.size() == 0) begin n_miss++; $display("FAIL ovf_spurious: d=%h, want no result", obs[15:0]); end
                else begin
                    want = q.pop_front();
                    if (obs !== want) begin n_miss++; $display("FAIL ovf_data: got b/o/d=%b/%b/%h want %b/%b/%h", obs[17], obs[16], obs[15:0], want[17], want[16], want[15:0]); end
                end
            end
        end
        n_vec++; if (q.size() != 0) begin n_miss++; $display("FAIL ovf_drain: %0d results missing, want 0", q.size()); q.delete(); end
    endtask

    task automatic test_backpressure();
        logic acc, cons, ov, ir, ordy, stall_prev;
        logic [17:0] obs, want, obs_prev;
        int idx, n_out;
        idx = 0; n_out = 0; stall_prev = 1'b0; obs_prev = '0;
        for (int c = 0; c < 20; c++) begin
            ordy = !(c >= 5 && c <= 7);
            if (idx < 6) cyc(1'b1, 16'(idx * 16'h1111), 16'h0001, 1'b0, ordy, acc, cons, ov, obs, ir);
            else         cyc(1'b0, '0, '0, 1'b0, ordy, acc, cons, ov, obs, ir);
            if (acc) idx++;
            if (c >= 5 && c <= 7) begin
                n_vec++; if (ir !== 1'b0) begin n_miss++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", c, ir); end
                n_vec++; if (ov !== 1'b1) begin n_miss++; $display("FAIL bp_valid: cycle %0d got %b want 1", c, ov); end
            end
            if (stall_prev) begin
                n_vec++;
                if (ov !== 1'b1 || obs !== obs_prev) begin n_miss++; $display("FAIL bp_stable: cycle %0d got v=%b %h want v=1 %h", c, ov, obs, obs_prev); end
            end
            stall_prev = ov && !ordy;
            obs_prev   = obs;
            if (cons) begin
                n_vec++; n_out++;
                if (q.size() == 0) begin n_miss++; $display("FAIL bp_spurious: d=%h, want no result", obs[15:0]); end
                else begin
                    want = q.pop_front();
                    if (obs !== want) begin n_miss++; $display("FAIL bp_data: got b/o/d=%b/%b/%h want %b/%b/%h", obs[17], obs[16], obs[15:0], want[17], want[16], want[15:0]); end
                end
            end
        end
        n_vec++; if (n_out != 6) begin n_miss++; $display("FAIL bp_count: got %0d results want 6", n_out); end
        q.delete();
    endtask

    task automatic test_throughput();
        logic acc, cons, ov, ir;
        logic [17:0] obs, want;
        for (int c = 0; c < 24; c++) begin
            if (c < 20) cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1, acc, cons, ov, obs, ir);
            else        cyc(1'b0, '0, '0, 1'b0, 1'b1, acc, cons, ov, obs, ir);
            if (c < 20) begin
                n_vec++; if (acc !== 1'b1) begin n_miss++; $display("FAIL tput_accept: cycle %0d got %b want 1", c, acc); end
            end
            n_vec++; if (cons !== (c >= 4)) begin n_miss++; $display("FAIL tput_rate: cycle %0d out_valid=%b want %b", c, cons, (c >= 4)); end
            if (cons) begin
                n_vec++;
                if (q.size() == 0) begin n_miss++; $display("FAIL tput_spurious: d=%h, want no result", obs[15:0]); end
                else begin
                    want = q.pop_front();
                    if (obs !== want) begin n_miss++; $display("FAIL tput_data: got b/o/d=%b/%b/%h want %b/%b/%h", obs[17], obs[16], obs[15:0], want[17], want[16], want[15:0]); end
                end
            end
        end
        n_vec++; if (q.size() != 0) begin n_miss++; $display("FAIL tput_drain: %0d results missing, want 0", q.size()); q.delete(); end
    endtask

    task automatic test_reset_midflight();
        logic acc, cons, ov, ir;
        logic [17:0] obs;
        for (int c = 0; c < 3; c++)
            cyc(1'b1, 16'($urandom) | 16'h0100, 16'($urandom), 1'b0, 1'b1, acc, cons, ov, obs, ir);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, acc, cons, ov, obs, ir);
        #3;
        n_vec++; if (out_valid !== 1'b1) begin n_miss++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        n_vec++; if (d !== 16'h0000)     begin n_miss++; $display("FAIL mid_rst_d: got %h want 0000", d); end
        n_vec++; if (bout !== 1'b0 || ovf !== 1'b0) begin n_miss++; $display("FAIL mid_rst_flags: got bout=%b ovf=%b want 0/0", bout, ovf); end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc(1'b0, '0, '0, 1'b0, 1'b1, acc, cons, ov, obs, ir);
            n_vec++; if (ov !== 1'b0) begin n_miss++; $display("FAIL mid_stale: cycle %0d out_valid=%b d=%h want 0", c, ov, obs[15:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_ovf();
        test_backpressure();
        test_throughput();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
